mbt_view_ctrl: RTL

MBT_VIEW_CTRL -- requirements
Module: mbt_view_ctrl

---
 rtl/mbt_view_ctrl.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/mbt_view_ctrl.sv
// mbt_view_ctrl
//   Turns three bouncing push-buttons plus two mode switches into zoom and
//   pan requests for a fractal view window. Each button has a 2-flop
//   synchroniser and a stable-time debouncer. Debounced rising edges latch
//   sticky pending flags. A small FSM (IDLE/APPLY/REQ) services one flag at
//   a time and hands each changed view to the render engine.
//
// Ports
//   clk, resetn        : clock, synchronous active-low reset
//   btn_zoom           : async button, zoom in/out (direction from sw_dir)
//   btn_pan_a/b        : async buttons, pan negative / positive
//   sw_dir             : 1 = zoom in, 0 = zoom out
//   sw_axis            : 0 = pan x, 1 = pan y
//   view_ack           : engine accepted the presented view
//   zoom_level         : current zoom level (0 = widest)
//   x_min, y_max       : signed left / top edge of the view
//   view_valid         : a new view is waiting for view_ack
//   busy               : controller is not idle
module mbt_view_ctrl #(
  parameter int                   ZOOM_LEVELS = 8,
  parameter int                   ZW          = 3,
  parameter int                   COORD_W     = 16,
  parameter logic [COORD_W-1:0]   X_MIN_INIT  = 16'hF000,
  parameter logic [COORD_W-1:0]   Y_MAX_INIT  = 16'h0960,
  parameter logic [COORD_W-1:0]   H_SPAN0     = 16'h1900,
  parameter logic [COORD_W-1:0]   V_SPAN0     = 16'h12C0,
  parameter int                   PAN_DIV     = 3,
  parameter int                   DB_CYCLES   = 1000000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               btn_zoom,
  input  logic               btn_pan_a,
  input  logic               btn_pan_b,
  input  logic               sw_dir,
  input  logic               sw_axis,
  input  logic               view_ack,
  output logic [ZW-1:0]      zoom_level,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] y_max,
  output logic               view_valid,
  output logic               busy
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_REQ} state_t;
  // Button bit order: 0 = zoom, 1 = pan_a, 2 = pan_b (also service priority)
  typedef enum logic [1:0] {OP_ZOOM, OP_PAN_A, OP_PAN_B} op_t;

  // ---------------- synchronise + debounce ----------------
  logic [2:0]    w_btn;
  logic [2:0]    r_sync1, r_sync2, r_db, r_db_d;
  logic [CW-1:0] r_cnt [3];
  logic [2:0]    w_rise;

  assign w_btn  = {btn_pan_b, btn_pan_a, btn_zoom};
  assign w_rise = r_db & ~r_db_d;

  // The debounced level flips only after DB_CYCLES consecutive samples
  // that disagree with it; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_d  <= '0;
      for (int unsigned i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      for (int unsigned i = 0; i < 3; i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_cnt[i] == CNT_LAST) begin
            r_db[i]  <= r_sync2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // ---------------- FSM ----------------
  state_t             r_state, w_state_nxt;
  op_t                r_op, w_op_sel;
  logic               r_dir, r_axis;
  logic [2:0]         r_pend, w_clr;
  logic               w_load;
  logic               r_view_valid, r_busy;
  logic               w_valid_nxt, w_busy_nxt;
  logic               w_changed;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_op         <= OP_ZOOM;
      r_dir        <= 1'b0;
      r_axis       <= 1'b0;
      r_pend       <= '0;
      r_view_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      // A new rising edge wins over the clear of the same flag
      r_pend       <= (r_pend & ~w_clr) | w_rise;
      r_view_valid <= w_valid_nxt;
      r_busy       <= w_busy_nxt;
      if (w_load) begin
        r_op   <= w_op_sel;
        r_dir  <= sw_dir;
        r_axis <= sw_axis;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = '0;
    w_op_sel    = OP_ZOOM;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend != '0) begin
          w_state_nxt = S_APPLY;
          w_load      = 1'b1;
          if (r_pend[0]) begin
            w_op_sel = OP_ZOOM;
            w_clr    = 3'b001;
          end else if (r_pend[1]) begin
            w_op_sel = OP_PAN_A;
            w_clr    = 3'b010;
          end else begin
            w_op_sel = OP_PAN_B;
            w_clr    = 3'b100;
          end
        end
      end
      S_APPLY: w_state_nxt = w_changed ? S_REQ : S_IDLE;
      S_REQ:   if (view_ack) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they come straight from flops
  always_comb begin
    w_valid_nxt = (w_state_nxt == S_REQ);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
  end

  // ---------------- view datapath ----------------
  logic [ZW-1:0]      r_zoom, w_z_new;
  logic [COORD_W-1:0] r_x, r_y, w_x_new, w_y_new;
  logic [COORD_W:0]   w_x_ext, w_y_ext, w_x_sum, w_y_sum;
  logic [COORD_W:0]   w_h_base, w_v_base, w_hstep, w_vstep;
  logic [7:0]         w_sh;

  // Two's-complement result one bit wider than the coordinate; clamp when
  // the top two bits disagree.
  function automatic logic [COORD_W-1:0] f_sat(input logic [COORD_W:0] v);
    if (v[COORD_W] == v[COORD_W-1]) return v[COORD_W-1:0];
    else if (v[COORD_W])            return {1'b1, {(COORD_W-1){1'b0}}};
    else                            return {1'b0, {(COORD_W-1){1'b1}}};
  endfunction

  assign w_x_ext  = {r_x[COORD_W-1], r_x};
  assign w_y_ext  = {r_y[COORD_W-1], r_y};
  assign w_h_base = {1'b0, H_SPAN0};
  assign w_v_base = {1'b0, V_SPAN0};
  assign w_hstep  = w_h_base >> w_sh;
  assign w_vstep  = w_v_base >> w_sh;

  always_comb begin
    w_sh = 8'(r_zoom) + 8'(PAN_DIV);
    if (r_op == OP_ZOOM) w_sh = r_dir ? 8'(r_zoom) + 8'd2 : 8'(r_zoom) + 8'd1;
  end

  always_comb begin
    w_x_sum = w_x_ext;
    w_y_sum = w_y_ext;
    w_z_new = r_zoom;
    case (r_op)
      OP_ZOOM: begin
        if (r_dir) begin
          if (r_zoom < ZW'(ZOOM_LEVELS - 1)) begin
            w_x_sum = w_x_ext + w_hstep;
            w_y_sum = w_y_ext - w_vstep;
            w_z_new = r_zoom + 1'b1;
          end
        end else if (r_zoom != '0) begin
          w_x_sum = w_x_ext - w_hstep;
          w_y_sum = w_y_ext + w_vstep;
          w_z_new = r_zoom - 1'b1;
        end
      end
      OP_PAN_A: begin
        if (r_axis) w_y_sum = w_y_ext - w_vstep;
        else        w_x_sum = w_x_ext - w_hstep;
      end
      OP_PAN_B: begin
        if (r_axis) w_y_sum = w_y_ext + w_vstep;
        else        w_x_sum = w_x_ext + w_hstep;
      end
      default: ;
    endcase
  end

  assign w_x_new   = f_sat(w_x_sum);
  assign w_y_new   = f_sat(w_y_sum);
  assign w_changed = (w_x_new != r_x) || (w_y_new != r_y) || (w_z_new != r_zoom);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_zoom <= '0;
      r_x    <= X_MIN_INIT;
      r_y    <= Y_MAX_INIT;
    end else if (r_state == S_APPLY) begin
      r_zoom <= w_z_new;
      r_x    <= w_x_new;
      r_y    <= w_y_new;
    end
  end

  assign zoom_level = r_zoom;
  assign x_min      = r_x;
  assign y_max      = r_y;
  assign view_valid = r_view_valid;
  assign busy       = r_busy;

endmodule
